// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIG_W      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scan_state_t;

  // Active-low anode pattern lighting exactly digit d.
  function automatic logic [NUM_DIGITS-1:0] an_lit(input logic [DIG_W-1:0] d);
    logic [NUM_DIGITS-1:0] one;
    one = NUM_DIGITS'(1);
    return ~(one << d);
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Scan-controller bus: host-side enables in, digit select and anode drive out.
interface seven_seg_scan_ctrl_if;
  import seven_seg_pkg::*;

  logic                  en;
  logic [NUM_DIGITS-1:0] digit_en;
  logic [DIG_W-1:0]      num;
  logic [NUM_DIGITS-1:0] an;
  logic                  frame_tick;

  modport master (output en, digit_en, input num, an, frame_tick);
  modport slave  (input en, digit_en, output num, an, frame_tick);
endinterface

// File: rtl/seven_seg_scan_ctrl_next_dig.sv
// Circular priority encoder: first set mask bit strictly after cur (cur+1 .. cur+8).
module seven_seg_next_dig
  import seven_seg_pkg::*;
(
  input  logic [DIG_W-1:0]      cur,
  input  logic [NUM_DIGITS-1:0] mask,
  output logic [DIG_W-1:0]      nxt,
  output logic                  wrap
);

  logic [DIG_W-1:0] idx;

  // Walk from the farthest candidate down so the nearest hit wins.
  always_comb begin
    nxt = cur;
    idx = cur;
    for (int i = NUM_DIGITS; i >= 1; i--) begin
      idx = cur + DIG_W'(i);
      if (mask[idx]) nxt = idx;
    end
    wrap = (nxt <= cur);
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 8-digit scan scheduler with masking, dead-time gap and frame tick.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  seven_seg_scan_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  scan_state_t           state;
  logic [CNT_W-1:0]      div_cnt;
  logic [DIG_W-1:0]      num_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  ft_q;

  logic [DIG_W-1:0]      next_dig, first_dig;
  logic                  wrap, first_wrap_unused;

  seven_seg_next_dig u_next (
    .cur  (num_q),
    .mask (bus.digit_en),
    .nxt  (next_dig),
    .wrap (wrap)
  );

  // Searching after digit 7 yields the lowest set bit.
  seven_seg_next_dig u_first (
    .cur  (DIG_W'(NUM_DIGITS - 1)),
    .mask (bus.digit_en),
    .nxt  (first_dig),
    .wrap (first_wrap_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      num_q   <= '0;
      an_q    <= '1;
      ft_q    <= 1'b0;
    end else if (!bus.en || bus.digit_en == '0) begin
      state   <= IDLE;
      div_cnt <= '0;
      an_q    <= '1;
      ft_q    <= 1'b0;
    end else begin
      ft_q <= 1'b0;
      case (state)
        IDLE: begin
          num_q   <= first_dig;
          div_cnt <= '0;
          an_q    <= an_lit(first_dig);
          state   <= SHOW;
        end
        SHOW: begin
          if (div_cnt == SHOW_LAST) begin
            div_cnt <= '0;
            if (BLANK_CYC > 0) begin
              state <= GAP;
              an_q  <= '1;
            end else begin
              num_q <= next_dig;
              an_q  <= an_lit(next_dig);
              ft_q  <= wrap;
            end
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
            // A digit masked off mid-SHOW goes dark for the rest of its slot.
            if (!bus.digit_en[num_q]) an_q <= '1;
          end
        end
        GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt <= '0;
            num_q   <= next_dig;
            an_q    <= an_lit(next_dig);
            ft_q    <= wrap;
            state   <= SHOW;
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.num        = num_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench: two DUTs (gap=2 and gap=0) share stimulus; a negedge monitor pops expectations.
module tb_seven_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] digit_en;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  string      phase = "init";

  typedef struct {
    int         which;
    int         cyc;
    bit         cn;
    logic [2:0] num;
    logic [7:0] an;
    logic       ft;
    string      tag;
  } exp_t;

  exp_t q[$];

  seven_seg_scan_ctrl_if ifa ();
  seven_seg_scan_ctrl_if ifb ();

  assign ifa.en = en;
  assign ifa.digit_en = digit_en;
  assign ifb.en = en;
  assign ifb.digit_en = digit_en;

  seven_seg_scan_ctrl #(.CLK_DIV(4), .BLANK_CYC(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  seven_seg_scan_ctrl #(.CLK_DIV(4), .BLANK_CYC(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: compare every expectation due on this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [2:0] n;
      logic [7:0] a;
      logic       f;
      e = q.pop_front();
      n = (e.which == 0) ? ifa.num : ifb.num;
      a = (e.which == 0) ? ifa.an : ifb.an;
      f = (e.which == 0) ? ifa.frame_tick : ifb.frame_tick;
      checks++;
      if (e.cyc != cyc || a !== e.an || f !== e.ft || (e.cn && n !== e.num)) begin
        errors++;
        $display("FAIL %s dut%0d cyc %0d (due %0d): got num=%0d an=%h ft=%b, want num=%0d%s an=%h ft=%b",
                 e.tag, e.which, cyc, e.cyc, n, a, f, e.num, e.cn ? "" : "(any)", e.an, e.ft);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int w, input bit cn, input int n, input logic [7:0] a, input logic f);
    exp_t e;
    e.which = w;
    e.cyc   = cyc + 1;
    e.cn    = cn;
    e.num   = 3'(n);
    e.an    = a;
    e.ft    = f;
    e.tag   = phase;
    q.push_back(e);
  endtask

  function automatic logic [7:0] lit(input int d);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << d);
  endfunction

  // Enable the scan with mask m from IDLE; expected outputs follow the periodic
  // description: slot of P cycles, lit for the first 4, tick on each wrap slot.
  task automatic scan_run(input logic [7:0] m, input int ncyc);
    int lst[$];
    for (int i = 0; i < 8; i++) if (m[i]) lst.push_back(i);
    en = 1'b1;
    digit_en = m;
    for (int k = 0; k < ncyc; k++) begin
      int s, p, d;
      s = k / 6; p = k % 6; d = lst[s % lst.size()];
      push(0, 1, d, (p < 4) ? lit(d) : 8'hFF, (p == 0 && s > 0 && s % lst.size() == 0));
      s = k / 4; p = k % 4; d = lst[s % lst.size()];
      push(1, 1, d, lit(d), (p == 0 && s > 0 && s % lst.size() == 0));
      tick();
    end
  endtask

  task automatic go_idle();
    en = 1'b0;
    push(0, 0, 0, 8'hFF, 1'b0);
    push(1, 0, 0, 8'hFF, 1'b0);
    tick();
  endtask

  initial begin
    phase = "reset";
    rst = 1'b1; en = 1'b1; digit_en = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      push(0, 1, 0, 8'hFF, 1'b0);
      push(1, 1, 0, 8'hFF, 1'b0);
      tick();
    end
    rst = 1'b0;

    phase = "full_scan";
    scan_run(8'hFF, 100);

    go_idle();
    phase = "sparse";
    scan_run(8'b1000_0101, 40);

    go_idle();
    phase = "single";
    scan_run(8'h10, 20);

    // Current digit masked off mid-SHOW: dark until next advance (gap=2 DUT only).
    go_idle();
    phase = "dark_mid_show";
    scan_run(8'hFF, 19);
    digit_en = 8'hF7;
    for (int k = 19; k <= 24; k++) begin
      if (k < 24) push(0, 1, 3, 8'hFF, 1'b0);
      else        push(0, 1, 4, 8'hEF, 1'b0);
      tick();
    end

    go_idle();
    phase = "mask_drop";
    scan_run(8'hFF, 20);
    digit_en = 8'h00;
    push(0, 1, 3, 8'hFF, 1'b0);
    push(1, 0, 0, 8'hFF, 1'b0);
    tick();
    phase = "mask_restore";
    scan_run(8'h30, 12);

    go_idle();
    phase = "en_drop";
    scan_run(8'hFF, 20);
    en = 1'b0;
    push(0, 1, 3, 8'hFF, 1'b0);
    push(1, 0, 0, 8'hFF, 1'b0);
    tick();
    phase = "en_restore";
    scan_run(8'h30, 6);

    go_idle();
    phase = "reset_mid_gap";
    scan_run(8'hFF, 35);
    rst = 1'b1;
    push(0, 1, 0, 8'hFF, 1'b0);
    push(1, 1, 0, 8'hFF, 1'b0);
    tick();
    rst = 1'b0;
    phase = "restart";
    scan_run(8'hFF, 10);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan scheduler for the 8-digit seven-segment display. It owns refresh timing and produces the digit index `num` that selects the BCD code from the 8-way digit mux. It also produces the matching active-low anode enables. It skips masked-off digits, inserts a dead-time gap between digits to suppress ghosting, and flags the end of each full scan frame.

Parameters:
CLK_DIV, 100000, clk cycles each digit is lit (SHOW phase); must be >= 2
BLANK_CYC, 1000, clk cycles of all-anodes-off gap after each digit; 0 = no gap; must be < CLK_DIV
NUM_DIGITS, 8, digit count; fixed at 8 for this display

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en  input  1  scan enable; 0 forces display dark
digit_en  input  8  per-digit enable mask; bit i = digit i participates in the scan
num  output  3  index of the current digit; drives the digit mux select
an  output  8  anode enables, active-low, one-hot-low while lit
frame_tick  output  1  one-cycle pulse when the scan wraps back to the lowest enabled digit

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Registered state:
  - state: IDLE, SHOW or GAP
  - div_cnt, width $clog2(CLK_DIV)
  - num, an, frame_tick
- Reset values: state=IDLE, div_cnt=0, num=3'd0, an=8'hFF, frame_tick=0.
- Output alignment: all outputs are registered. `an` and `num` update on the same edge, so `an` never lights a digit other than `num`.
- an encoding: an = ~(8'b1 << num) in SHOW; 8'hFF in IDLE and GAP.
- IDLE:
  - Exit when en=1 and digit_en!=0.
  - On exit: num <= lowest set bit of digit_en, div_cnt <= 0, go to SHOW.
- SHOW:
  - div_cnt increments each cycle.
  - At div_cnt==CLK_DIV-1: div_cnt <= 0.
  - If BLANK_CYC>0, go to GAP.
  - If BLANK_CYC==0, advance immediately (same rules as leaving GAP).
- GAP:
  - div_cnt counts to BLANK_CYC-1.
  - Then num <= next enabled digit strictly after num, searched circularly (num+1 .. num+8 mod 8), and go to SHOW.
- Next-digit selection:
  - Uses the digit_en value sampled on the advance edge.
  - A single enabled digit selects itself again; the gap is still inserted.
- frame_tick:
  - Pulses 1 cycle, coincident with the advance edge, when the selected next digit <= current num (wrap or self).
  - Never asserted in IDLE.
- Per-digit period: CLK_DIV+BLANK_CYC cycles.
- Frame period: (number of enabled digits) × (CLK_DIV+BLANK_CYC).
- Mask change mid-SHOW: takes effect at the next advance. Exception: if the current digit's bit clears, an <= 8'hFF on the next edge and the remaining SHOW/GAP time is spent dark.
- en=0 or digit_en==0 in any state: next edge goes to IDLE with an=8'hFF, div_cnt=0, frame_tick=0; num holds its value.
- rst has priority over everything. Asserting it mid-operation returns all registers to reset values on that edge.

Decomposition:
- Package seven_seg_pkg:
  - scan_state_t enum (IDLE, SHOW, GAP)
  - NUM_DIGITS=8
  - DIG_W=3
- One combinational sub-module, seven_seg_next_dig:
  - Inputs: cur[2:0], mask[7:0].
  - Outputs: nxt[2:0], wrap (circular priority encoder).
  - Also reused to find the lowest set bit (cur=7).

Test Plan:
(All scenarios use CLK_DIV=4, BLANK_CYC=2.)
- Reset: rst=1 for 3 cycles with en=1, digit_en=8'hFF -> num=0, an=8'hFF, frame_tick=0 throughout. First SHOW appears the cycle after rst drops.
- Full scan: en=1, digit_en=8'hFF -> num steps 0..7.
  - an is FE,FD,...,7F for 4 cycles each, with 2 cycles of FF between digits.
  - frame_tick pulses once per 48 cycles, on the 7->0 advance.
- Sparse mask: digit_en=8'b1000_0101 -> num 0,2,7,0,...; an FE,FB,7F; frame_tick every 18 cycles.
- Single digit and zero gap:
  - digit_en=8'h10 -> num stays 4, an=EF for 4 cycles then FF for 2; frame_tick every 6 cycles.
  - Rerun with BLANK_CYC=0 -> an constantly EF, frame_tick every 4 cycles.
- Mask/enable drop: clear digit_en to 0 in the 2nd SHOW cycle of digit 3 -> next edge an=FF, IDLE.
  - Restore 8'h30 -> next edge num=4, an=EF.
  - Same result for an en pulse low/high.
- Reset mid-GAP: assert rst during GAP after digit 5 -> next edge num=0, an=FF, frame_tick=0. Release with en=1 -> scan restarts at digit 0.
